// File: rtl/voice_allocator_if.sv
// Note source / note player bundle for the voice allocator.
// Carries the request handshake, the player status and the load broadcast.
interface voice_allocator_if #(
    parameter int N_VOICES = 8,
    parameter int NOTE_W   = 15
) ();
    logic                note_valid;
    logic [NOTE_W-1:0]   note_in;
    logic                note_ready;
    logic [N_VOICES-1:0] available;
    logic [N_VOICES-1:0] load_np;
    logic [NOTE_W-1:0]   note_out;
    logic                stole;
    logic [3:0]          active_voices;
    logic                ack_timeout;

    modport master (
        output note_valid, note_in, available,
        input  note_ready, load_np, note_out, stole, active_voices, ack_timeout
    );

    modport slave (
        input  note_valid, note_in, available,
        output note_ready, load_np, note_out, stole, active_voices, ack_timeout
    );
endinterface

// File: rtl/voice_allocator.sv
// Sequential voice scheduler: round-robin over free players, steals the
// oldest-allocated player when none is free, then waits for the player ack.
module voice_allocator #(
    parameter int N_VOICES    = 8,
    parameter int NOTE_W      = 15,
    parameter int AGE_W       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input logic             clk,
    input logic             reset,
    voice_allocator_if.slave bus
);
    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_VOICES - 1);
    localparam logic [N_VOICES-1:0] ONE = N_VOICES'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, CONFIRM} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   rr_ptr, target, sel, rr_idx, old_idx;
    logic               rr_hit, stole_pending, ack_err;
    logic [CNT_W-1:0]   cnt;
    logic [NOTE_W-1:0]  note_q;
    logic [AGE_W-1:0]   age [N_VOICES];
    logic [AGE_W-1:0]   old_age;
    logic [3:0]         active, pop;

    // Free voice: first set bit at or above rr_ptr, wrapping.
    // Steal: largest age, lowest index on ties.
    always_comb begin
        int j;
        rr_hit  = 1'b0;
        rr_idx  = '0;
        old_idx = '0;
        old_age = age[0];
        j       = 0;
        for (int i = 0; i < N_VOICES; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_VOICES) j = j - N_VOICES;
            if (!rr_hit && bus.available[j]) begin
                rr_hit = 1'b1;
                rr_idx = IDX_W'(j);
            end
        end
        for (int i = 1; i < N_VOICES; i++) begin
            if (age[i] > old_age) begin
                old_age = age[i];
                old_idx = IDX_W'(i);
            end
        end
        sel = rr_hit ? rr_idx : old_idx;
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_VOICES; i++)
            pop = pop + 4'(!bus.available[i]);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.note_valid) state_next = ISSUE;
            ISSUE:   state_next = CONFIRM;
            CONFIRM: if (!bus.available[target] || cnt == CNT_LAST)
                         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            target        <= '0;
            cnt           <= '0;
            stole_pending <= 1'b0;
            note_q        <= '0;
            ack_err       <= 1'b0;
            active        <= '0;
            for (int i = 0; i < N_VOICES; i++) age[i] <= '0;
        end else begin
            state  <= state_next;
            active <= pop;
            unique case (state)
                IDLE: if (bus.note_valid) begin
                    note_q        <= bus.note_in;
                    target        <= sel;
                    stole_pending <= !rr_hit;
                end
                ISSUE: begin
                    rr_ptr <= (target == IDX_LAST) ? '0 : target + 1'b1;
                    cnt    <= '0;
                    for (int i = 0; i < N_VOICES; i++) begin
                        if (IDX_W'(i) == target) age[i] <= '0;
                        else if (age[i] != '1)   age[i] <= age[i] + 1'b1;
                    end
                end
                CONFIRM: if (bus.available[target]) begin
                    if (cnt == CNT_LAST) ack_err <= 1'b1;
                    else                 cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.note_ready    = (state == IDLE);
    assign bus.load_np       = (state == ISSUE) ? (ONE << target) : '0;
    assign bus.stole         = (state == ISSUE) && stole_pending;
    assign bus.note_out      = note_q;
    assign bus.active_voices = active;
    assign bus.ack_timeout   = ack_err;
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Sequential voice scheduler between the song/jam note source and the eight composite note players. Accepts one note request at a time over a valid/ready handshake and selects a target player: round-robin among players reporting `available`, or the oldest-allocated player (voice stealing) when none is free. Issues a one-cycle one-hot load strobe and waits for the player to take the note before accepting the next request. It replaces the purely combinational free-player arbitration and load gating.

## Interface
- `N_VOICES`, default 8: number of note players; `load_np` and `available` are this wide.
- `NOTE_W`, default 15: width of a song note word.
- `AGE_W`, default 8: width of each per-voice age counter; counters saturate.
- `ACK_TIMEOUT`, default 4: cycles in CONFIRM before giving up on the player acknowledge.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `note_valid`  in  1  request holds a note on `note_in`.
- `note_in`  in  NOTE_W  note word to load.
- `note_ready`  out  1  allocator can accept a request; transfer when `note_valid & note_ready` at a rising edge.
- `available`  in  N_VOICES  per-player free flag from the note players.
- `load_np`  out  N_VOICES  one-hot load strobe, high for exactly one cycle per accepted note.
- `note_out`  out  NOTE_W  registered note broadcast to all players; valid while `load_np` is nonzero.
- `stole`  out  1  high in the same cycle as `load_np` when the target was not available (steal).
- `active_voices`  out  4  population count of `~available`, registered.
- `ack_timeout`  out  1  sticky error flag: a player never dropped `available` after a load.

## Operation
- States: IDLE, ISSUE, CONFIRM. `note_ready = (state == IDLE)`.
- IDLE, on a transfer:
  - Latch `note_in` into `note_out`.
  - If `available` is nonzero, target is the first set bit scanning upward from `rr_ptr` with wrap-around.
  - Otherwise target is the voice with the largest age (ties go to the lowest index), and `stole_pending` is set.
  - Go to ISSUE.
- ISSUE:
  - Drive `load_np = 1 << target`, and drive `stole` if pending.
  - `rr_ptr <= (target + 1) mod N_VOICES`.
  - `age[target] <= 0`; every other age increments, saturating at all-ones.
  - Clear the timeout counter and go to CONFIRM.
- CONFIRM:
  - If `available[target] == 0`, go to IDLE.
  - Else if the counter equals `ACK_TIMEOUT - 1`, set `ack_timeout` and go to IDLE.
  - Else increment the counter.
  - A stolen voice already reads 0, so CONFIRM completes in its first cycle.
- `note_valid` deasserted in IDLE: no state change. `note_in` is ignored outside IDLE.
- `available` changes in IDLE have no effect until the next transfer.
- Reset, in any state:
  - State returns to IDLE, `rr_ptr` = 0, all ages = 0, timeout counter = 0.
  - `load_np` = 0, `stole` = 0, `note_out` = 0, `active_voices` = 0, `ack_timeout` = 0, `note_ready` = 1.
  - A note in flight is dropped. A strobe already issued is not retracted.
- `active_voices` updates every cycle from `available`, one cycle late.

## Timing
- Transfer at edge T: `load_np`, `stole` and `note_out` are valid during cycle T..T+1 (the ISSUE cycle).
- CONFIRM begins at edge T+1. If `available[target]` is low at edge T+2, `note_ready` is high from T+2.
- Best-case throughput: one note per 3 cycles.
- Worst case: `ACK_TIMEOUT + 2` cycles per note.
- `note_out` holds its value until the next transfer.
- Exactly one `load_np` bit is ever high, for exactly one cycle.
- Age and pointer updates take effect at the edge ending ISSUE and are visible to the next selection.

## Test plan
- **Reset then single note.** Stimulus: `available = 8'hFF`, `note_in = 15'h1234` valid one cycle. Response: `load_np = 8'h01` for one cycle, `note_out = 15'h1234`, `stole = 0`. The bench drops `available[0]` and `note_ready` returns 2 cycles after the load.
- **Round-robin.** Stimulus: all free, 4 back-to-back notes, bench clears each granted bit. Response: `load_np` = 01, 02, 04, 08. Then with `available = 8'hF1`, the next grant is 8'h10.
- **Steal oldest.** Stimulus: fill all 8 voices in order 0..7, `available = 0`, send one more note. Response: `load_np = 8'h01`, `stole = 1`, CONFIRM lasts 1 cycle. The following steal targets voice 1.
- **Timeout.** Stimulus: `available` stuck at 8'hFF after a load. Response: `ack_timeout` sets after 4 CONFIRM cycles and stays 1. `note_ready` returns, and the next grant is voice 1.
- **Reset mid-operation.** Stimulus: assert `reset` during CONFIRM. Response: next cycle `note_ready = 1`, `load_np = 0`, `note_out = 0`, `rr_ptr = 0`, so the next grant with all voices free is 8'h01.
- **Valid held with backpressure.** Stimulus: `note_valid` held high for 10 cycles with changing `note_in`. Response: only values sampled while `note_ready = 1` are loaded, and no strobe occurs outside ISSUE.
